ibex_fetch_aligner: RTL



---
 rtl/ibex_pkg.sv | 18 +
 rtl/ibex_fetch_aligner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// Shared fetch-path definitions: compressed-opcode mask, fetch FIFO word record
// and a helper that classifies a 16-bit parcel.
package ibex_pkg;

  localparam logic [1:0] OPCODE_C_MASK = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_word_t;

  // A parcel is compressed unless its two lowest opcode bits are both set.
  function automatic logic is_compressed(input logic [1:0] opc);
    return (opc & OPCODE_C_MASK) != OPCODE_C_MASK;
  endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Splits/stitches 32-bit fetch words into RV32/RVC instruction parcels with PC and
// bus-error tagging; a redirect flushes the one-word buffer and restarts.
module ibex_fetch_aligner
  import ibex_pkg::*;
#(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic [31:0] in_addr_i,
  input  logic        in_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  logic [31:0] word_q, word_d;
  logic [29:0] waddr_q, waddr_d;
  logic        werr_q, werr_d;
  logic        wvalid_q, wvalid_d;
  logic        hsel_q, hsel_d;
  logic        hold_q, hold_d;

  fetch_word_t in_word;
  logic        lo_c, hi_c;
  logic        active, straddle, out_hs, in_hs, consumed;
  logic        unused_bits;

  assign in_word = '{rdata: in_rdata_i, addr: in_addr_i, err: in_err_i};
  assign unused_bits = ^{in_word.addr[1:0], redirect_addr_i[31:2], redirect_addr_i[0]};

  assign lo_c     = is_compressed(word_q[1:0]);
  assign hi_c     = is_compressed(word_q[17:16]);
  assign active   = wvalid_q & ~hold_q & ~redirect_i;
  // Upper half starts a 32-bit instruction: the rest lives in the incoming word.
  assign straddle = active & ~werr_q & hsel_q & ~hi_c;

  always_comb begin
    out_valid_o     = 1'b0;
    out_instr_o     = 32'h0;
    out_pc_o        = 32'h0;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;
    if (active) begin
      out_pc_o = {waddr_q, hsel_q, 1'b0};
      if (werr_q) begin
        out_valid_o = 1'b1;
        out_err_o   = 1'b1;
      end else if (!hsel_q) begin
        out_valid_o = 1'b1;
        out_instr_o = lo_c ? {16'h0, word_q[15:0]} : word_q;
      end else if (hi_c) begin
        out_valid_o = 1'b1;
        out_instr_o = {16'h0, word_q[31:16]};
      end else begin
        out_valid_o     = in_word.err | in_valid_i ? in_valid_i : 1'b0;
        out_instr_o     = {in_word.rdata[15:0], word_q[31:16]};
        out_err_o       = in_word.err;
        out_err_plus2_o = in_word.err;
      end
    end
    if (!out_valid_o) begin
      out_instr_o     = 32'h0;
      out_pc_o        = 32'h0;
      out_err_o       = 1'b0;
      out_err_plus2_o = 1'b0;
    end
  end

  assign out_hs   = out_valid_o & out_ready_i;
  assign consumed = out_hs & ~werr_q & (hsel_q ? hi_c : ~lo_c);

  always_comb begin
    if (straddle) begin
      in_ready_o = out_ready_i;
    end else begin
      in_ready_o = ~redirect_i & ~hold_q & (~wvalid_q | consumed);
    end
  end

  assign in_hs = in_valid_i & in_ready_o;

  always_comb begin
    word_d   = word_q;
    waddr_d  = waddr_q;
    werr_d   = werr_q;
    wvalid_d = wvalid_q;
    hsel_d   = hsel_q;
    hold_d   = hold_q;
    if (redirect_i) begin
      wvalid_d = 1'b0;
      hold_d   = 1'b0;
      hsel_d   = redirect_addr_i[1];
    end else if (out_hs && (werr_q || (straddle && in_word.err))) begin
      // Error beat delivered: stall until the core redirects.
      hold_d   = 1'b1;
      wvalid_d = 1'b0;
    end else begin
      if (out_hs && !straddle) begin
        hsel_d = ~hsel_q & lo_c;
      end
      if (in_hs) begin
        word_d   = in_word.rdata;
        waddr_d  = in_word.addr[31:2];
        werr_d   = in_word.err;
        wvalid_d = 1'b1;
      end else if (consumed) begin
        wvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q   <= 32'h0;
      waddr_q  <= ResetPc[31:2];
      werr_q   <= 1'b0;
      wvalid_q <= 1'b0;
      hsel_q   <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      word_q   <= word_d;
      waddr_q  <= waddr_d;
      werr_q   <= werr_d;
      wvalid_q <= wvalid_d;
      hsel_q   <= hsel_d;
      hold_q   <= hold_d;
    end
  end

endmodule
